// File: rtl/camera_stream_mux.sv
// camera_stream_mux: frame-boundary switching of NUM_INPUTS camera feeds onto pipeline and screen outputs.
// Define CAMERA_STREAM_MUX_FRAME_COUNT_EN to compile in per-output 16-bit frame counters.
module camera_stream_mux #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter logic [7:0] CUSTOM_INSTRUCTION_ID = 8'd0
) (
    input  logic                             pixelClock,
    input  logic                             reset,
    input  logic [NUM_INPUTS-1:0]            href,
    input  logic [NUM_INPUTS-1:0]            vsync,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] camData,
    output logic                             hrefPipeline,
    output logic                             vsyncPipeline,
    output logic [DATA_WIDTH-1:0]            camDataPipeline,
    output logic                             hrefScreen,
    output logic                             vsyncScreen,
    output logic [DATA_WIDTH-1:0]            camDataScreen,
    input  logic                             ciStart,
    input  logic                             ciCke,
    input  logic [7:0]                       ciN,
    input  logic [31:0]                      ciValueA,
    input  logic [31:0]                      ciValueB,
    output logic [31:0]                      ciResult,
    output logic                             ciDone
);
    typedef enum logic {IDLE, PENDING} muxState;
    localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);

    logic isMyCi, requestBad, errorBit, unusedCiBits;
    logic [2:0] command, requestSel;
    logic [7:0] hrefPad, vsyncPad;
    logic [8*DATA_WIDTH-1:0] dataPad;
    muxState state [2];
    logic [2:0] committedSel [2];
    logic [2:0] pendingSel [2];
    logic [2:0] baseSel [2];
    logic [23:0] timeoutCount [2];
    logic [1:0] vsyncPrev, justCommitted, commit, request, hrefOut, vsyncOut;
    logic [DATA_WIDTH-1:0] dataOut [2];
    logic [31:0] status, pipelineCount, screenCount;

    assign isMyCi = ciStart & ciCke & (ciN == CUSTOM_INSTRUCTION_ID);
    assign ciDone = isMyCi;
    assign command = ciValueA[2:0];
    assign requestSel = ciValueB[2:0];
    assign requestBad = {29'd0, requestSel} >= 32'(NUM_INPUTS);
    assign unusedCiBits = ^{ciValueA[31:3], ciValueB[31:3]};
    // Pad feeds to 8 so a 3-bit select always indexes in range.
    assign hrefPad = 8'(href);
    assign vsyncPad = 8'(vsync);
    assign dataPad = (8*DATA_WIDTH)'(camData);

    // Index 0 is the pipeline output (command 1), index 1 the screen output (command 0).
    always_comb begin
        for (int o = 0; o < 2; o++) begin
            request[o] = isMyCi && !requestBad && command == (o == 0 ? 3'd1 : 3'd0);
            commit[o] = state[o] == PENDING && ((vsyncPad[committedSel[o]] && !vsyncPrev[o] && !justCommitted[o]) || timeoutCount[o] == TIMEOUT_LAST);
            baseSel[o] = commit[o] ? pendingSel[o] : committedSel[o];
        end
    end

    always_ff @(posedge pixelClock or negedge reset) begin
        if (!reset) begin
            errorBit <= 1'b0;
            vsyncPrev <= '0;
            justCommitted <= '0;
            hrefOut <= '0;
            vsyncOut <= '0;
            for (int o = 0; o < 2; o++) begin
                state[o] <= IDLE;
                committedSel[o] <= '0;
                pendingSel[o] <= '0;
                timeoutCount[o] <= '0;
                dataOut[o] <= '0;
            end
        end else begin
            if (isMyCi && requestBad && command <= 3'd1)
                errorBit <= 1'b1;
            else if (isMyCi && command == 3'd2)
                errorBit <= 1'b0;
            for (int o = 0; o < 2; o++) begin
                vsyncPrev[o] <= vsyncPad[committedSel[o]];
                justCommitted[o] <= commit[o];
                hrefOut[o] <= hrefPad[committedSel[o]];
                vsyncOut[o] <= vsyncPad[committedSel[o]];
                dataOut[o] <= dataPad[int'(committedSel[o])*DATA_WIDTH +: DATA_WIDTH];
                if (commit[o])
                    committedSel[o] <= pendingSel[o];
                if (request[o] && requestSel != baseSel[o]) begin
                    state[o] <= PENDING;
                    pendingSel[o] <= requestSel;
                    timeoutCount[o] <= '0;
                end else if (request[o] || commit[o]) begin
                    state[o] <= IDLE;
                    timeoutCount[o] <= '0;
                end else if (state[o] == PENDING) begin
                    timeoutCount[o] <= timeoutCount[o] + 24'd1;
                end
            end
        end
    end

`ifdef CAMERA_STREAM_MUX_FRAME_COUNT_EN
    logic [1:0] vsyncOutPrev;
    logic [15:0] frameCount [2];

    always_ff @(posedge pixelClock or negedge reset) begin
        if (!reset) begin
            vsyncOutPrev <= '0;
            frameCount[0] <= '0;
            frameCount[1] <= '0;
        end else begin
            vsyncOutPrev <= vsyncOut;
            for (int o = 0; o < 2; o++) begin
                if (isMyCi && command == 3'd5)
                    frameCount[o] <= '0;
                else if (vsyncOut[o] && !vsyncOutPrev[o])
                    frameCount[o] <= frameCount[o] + 16'd1;
            end
        end
    end

    assign pipelineCount = {16'd0, frameCount[0]};
    assign screenCount = {16'd0, frameCount[1]};
`else
    assign pipelineCount = '0;
    assign screenCount = '0;
`endif

    assign status = {23'd0, errorBit, state[1] == PENDING, state[0] == PENDING, committedSel[1], committedSel[0]};
    assign ciResult = !isMyCi ? 32'd0 :
                      command == 3'd2 ? status :
                      command == 3'd3 ? pipelineCount :
                      command == 3'd4 ? screenCount : 32'd0;

    assign hrefPipeline = hrefOut[0];
    assign vsyncPipeline = vsyncOut[0];
    assign camDataPipeline = dataOut[0];
    assign hrefScreen = hrefOut[1];
    assign vsyncScreen = vsyncOut[1];
    assign camDataScreen = dataOut[1];
endmodule
